// File: rtl/led_pwm_controller_if.sv
// Avalon-MM slave bus bundle for the LED PWM controller.
interface led_pwm_controller_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, read, write, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, read, write, writedata,
    output readdata
  );
endinterface

// File: rtl/led_pwm_controller.sv
// LED bank driver: enable mask, global PWM brightness and per-LED blinking,
// controlled through four Avalon-MM registers.
module led_pwm_controller #(
  parameter int NUM_LEDS = 10,
  parameter int PWM_BITS = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  led_pwm_controller_if.slave   bus,
  output logic [NUM_LEDS-1:0]   led_out
);

  localparam logic [PWM_BITS-1:0] PWM_MAX = {PWM_BITS{1'b1}};

  logic [NUM_LEDS-1:0] data_q, data_d;
  logic [NUM_LEDS-1:0] blink_q, blink_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [15:0]         period_q, period_d;
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [15:0]         blink_cnt_q, blink_cnt_d;
  logic                blink_phase_q, blink_phase_d;
  logic [31:0]         readdata_q, readdata_d;
  logic [NUM_LEDS-1:0] led_out_q, led_out_d;

  logic        wr_en, rd_en, period_wr, frame_end, pwm_on;
  logic [31:0] rd_mux;
  logic        unused_wdata_bits;

  assign wr_en     = bus.chipselect & bus.write;
  assign rd_en     = bus.chipselect & bus.read & ~bus.write;
  assign period_wr = wr_en && (bus.address == 2'd3);
  assign frame_end = (pwm_cnt_q == PWM_MAX);
  assign pwm_on    = (duty_q == PWM_MAX) || (pwm_cnt_q < duty_q);

  assign unused_wdata_bits = ^bus.writedata;

  always_comb begin
    data_d   = data_q;
    blink_d  = blink_q;
    duty_d   = duty_q;
    period_d = period_q;
    if (wr_en) begin
      case (bus.address)
        2'd0: data_d   = bus.writedata[NUM_LEDS-1:0];
        2'd1: blink_d  = bus.writedata[NUM_LEDS-1:0];
        2'd2: duty_d   = bus.writedata[PWM_BITS-1:0];
        default: period_d = bus.writedata[15:0];
      endcase
    end
  end

  // A PERIOD write restarts the half-period from the lit phase.
  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (period_wr || (period_q == 16'd0)) begin
      blink_cnt_d   = 16'd0;
      blink_phase_d = 1'b1;
    end else if (frame_end) begin
      if (blink_cnt_q == period_q - 16'd1) begin
        blink_cnt_d   = 16'd0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 16'd1;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      2'd0: rd_mux[NUM_LEDS-1:0] = data_q;
      2'd1: rd_mux[NUM_LEDS-1:0] = blink_q;
      2'd2: rd_mux[PWM_BITS-1:0] = duty_q;
      default: rd_mux[15:0] = period_q;
    endcase
    readdata_d = rd_en ? rd_mux : 32'd0;
    led_out_d  = data_q & {NUM_LEDS{pwm_on}} & (~blink_q | {NUM_LEDS{blink_phase_q}});
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q        <= '0;
      blink_q       <= '0;
      duty_q        <= PWM_MAX;
      period_q      <= 16'd0;
      pwm_cnt_q     <= '0;
      blink_cnt_q   <= 16'd0;
      blink_phase_q <= 1'b1;
      readdata_q    <= 32'd0;
      led_out_q     <= '0;
    end else begin
      data_q        <= data_d;
      blink_q       <= blink_d;
      duty_q        <= duty_d;
      period_q      <= period_d;
      pwm_cnt_q     <= pwm_cnt_q + PWM_BITS'(1);
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      readdata_q    <= readdata_d;
      led_out_q     <= led_out_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign led_out      = led_out_q;

endmodule

// File: tb/tb_led_pwm_controller.sv
// Directed bench for led_pwm_controller with NUM_LEDS=10, PWM_BITS=4.
module tb_led_pwm_controller;

  logic       clk;
  logic       reset_n;
  logic [9:0] led_out;
  int         checks = 0;
  int         errors = 0;

  led_pwm_controller_if bus ();

  led_pwm_controller #(.NUM_LEDS(10), .PWM_BITS(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .led_out (led_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic bus_idle();
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    bus.address    = 2'd0;
    bus.writedata  = 32'd0;
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.chipselect = 1'b1;
    bus.write      = 1'b1;
    bus.address    = addr;
    bus.writedata  = data;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic bus_read_chk(input logic [1:0] addr, input logic [31:0] exp, input string name);
    @(negedge clk);
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    bus.address    = addr;
    @(negedge clk);
    bus_idle();
    chk(name, bus.readdata, exp);
    @(negedge clk);
    chk({name, "_hold0"}, bus.readdata, 32'd0);
  endtask

  task automatic count_on(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (led_out[0] === 1'b1) cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt, bad, first_off, run, found;

    vecs[0] = '{2'd0, 32'h0000_0155, 32'h155};
    vecs[1] = '{2'd1, 32'hFFFF_FFFF, 32'h3FF};
    vecs[2] = '{2'd2, 32'h0000_1234, 32'h4};
    vecs[3] = '{2'd3, 32'h000A_BCDE, 32'hBCDE};
    vecs[4] = '{2'd1, 32'h0000_0000, 32'h0};
    vecs[5] = '{2'd0, 32'hFFFF_FC00, 32'h0};

    reset_n = 1'b0;
    bus_idle();
    repeat (3) @(negedge clk);
    chk("reset_led_out", led_out, 0);
    chk("reset_readdata", bus.readdata, 0);
    reset_n = 1'b1;

    // Full brightness from the cycle after the write.
    bus_write(2'd0, 32'h3FF);
    chk("led_at_write_edge", led_out, 0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (led_out !== 10'h3FF) bad++;
    end
    chk("led_full_steady_bad", bad, 0);
    bus_read_chk(2'd2, 32'hF, "duty_reset_val");

    // PWM duty cycle.
    bus_write(2'd2, 32'd4);
    bus_write(2'd0, 32'h001);
    @(negedge clk);
    count_on(16, cnt);
    chk("duty4_on_of16", cnt, 4);
    count_on(32, cnt);
    chk("duty4_on_of32", cnt, 8);
    bus_write(2'd2, 32'd0);
    @(negedge clk);
    count_on(16, cnt);
    chk("duty0_on_of16", cnt, 0);
    bus_write(2'd2, 32'hF);
    @(negedge clk);
    count_on(16, cnt);
    chk("dutyF_on_of16", cnt, 16);

    // Blinking with PERIOD=2: 32-cycle half-period.
    bus_write(2'd0, 32'h003);
    bus_write(2'd1, 32'h002);
    bus_write(2'd3, 32'd2);
    bad = 0;
    first_off = 0;
    for (int s = 1; s <= 40 && first_off == 0; s++) begin
      @(negedge clk);
      if (led_out[0] !== 1'b1) bad++;
      if (s == 1) chk("blink_starts_lit", led_out[1], 1);
      if (led_out[1] === 1'b0) first_off = s;
    end
    chk("blink_first_off_in_window", (first_off >= 18 && first_off <= 33), 1);
    run = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (led_out[0] !== 1'b1) bad++;
      if (led_out[1] !== 1'b0) break;
      run++;
    end
    chk("blink_off_run", run, 32);
    run = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (led_out[0] !== 1'b1) bad++;
      if (led_out[1] !== 1'b1) break;
      run++;
    end
    chk("blink_on_run", run, 32);
    chk("blink_led0_steady_bad", bad, 0);
    bus_write(2'd3, 32'd0);
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (led_out !== 10'h003) bad++;
    end
    chk("period0_lit_bad", bad, 0);

    // Read-back of all registers.
    bus_write(2'd1, 32'h0);
    bus_write(2'd0, 32'h155);
    bus_read_chk(2'd0, 32'h155, "rd_data");
    bus_read_chk(2'd1, 32'h0,   "rd_blink");
    bus_read_chk(2'd2, 32'hF,   "rd_duty");
    bus_read_chk(2'd3, 32'h0,   "rd_period");

    for (int v = 0; v < 6; v++) begin
      bus_write(vecs[v].addr, vecs[v].wdata);
      bus_read_chk(vecs[v].addr, vecs[v].exp, $sformatf("vec%0d_addr%0d", v, vecs[v].addr));
    end
    bus_write(2'd3, 32'd0);
    bus_write(2'd2, 32'hF);

    // Write and read together: write wins.
    @(negedge clk);
    bus.chipselect = 1'b1;
    bus.write      = 1'b1;
    bus.read       = 1'b1;
    bus.address    = 2'd0;
    bus.writedata  = 32'h2AA;
    @(negedge clk);
    bus_idle();
    chk("wr_rd_together_readdata", bus.readdata, 0);
    bus_read_chk(2'd0, 32'h2AA, "wr_rd_together_data");

    // Write without chipselect is ignored.
    @(negedge clk);
    bus.write     = 1'b1;
    bus.address   = 2'd0;
    bus.writedata = 32'h0F0;
    @(negedge clk);
    bus_idle();
    bus_read_chk(2'd0, 32'h2AA, "nocs_write_ignored");

    // Asynchronous reset mid-blink.
    bus_write(2'd0, 32'h3FF);
    bus_write(2'd1, 32'h002);
    bus_write(2'd3, 32'd1);
    bus_write(2'd2, 32'd3);
    repeat (20) @(negedge clk);
    @(negedge clk);
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    bus.address    = 2'd2;
    found = 0;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk);
      #1;
      if (led_out !== 10'h0) begin
        found = 1;
        break;
      end
    end
    chk("lit_before_reset", found, 1);
    chk("readdata_before_reset", bus.readdata, 3);
    reset_n = 1'b0;
    #1;
    chk("async_reset_led_out", led_out, 0);
    chk("async_reset_readdata", bus.readdata, 0);
    bus_idle();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    bus_read_chk(2'd2, 32'hF, "post_reset_duty");
    bus_read_chk(2'd3, 32'h0, "post_reset_period");
    bus_read_chk(2'd0, 32'h0, "post_reset_data");
    bus_read_chk(2'd1, 32'h0, "post_reset_blink");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
